// File: rtl/sm_xbee_pkg.sv
// Shared types, ASCII constants and message-layout helpers for the Xbee message transmitter.
package sm_xbee_pkg;

    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_D    = 8'h44;
    localparam logic [7:0] CH_E    = 8'h45;
    localparam logic [7:0] CH_I    = 8'h49;
    localparam logic [7:0] CH_M    = 8'h4D;
    localparam logic [7:0] CH_N    = 8'h4E;
    localparam logic [7:0] CH_P    = 8'h50;
    localparam logic [7:0] CH_S    = 8'h53;
    localparam logic [7:0] CH_V    = 8'h56;
    localparam logic [7:0] CH_W    = 8'h57;
    localparam logic [7:0] CH_Z    = 8'h5A;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_2    = 8'h32;
    localparam logic [7:0] CH_3    = 8'h33;
    localparam logic [7:0] CH_NL   = 8'h0A;
    // Fallback character for codes that validation never lets through.
    localparam logic [7:0] CH_BAD  = 8'h3F;

    typedef enum logic [1:0] {
        MsgEnd  = 2'd0,
        MsgSi   = 2'd1,
        MsgSpim = 2'd2,
        MsgSdm  = 2'd3
    } msg_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StDone
    } ctrl_state_e;

    typedef struct packed {
        msg_type_e  mtype;
        logic [1:0] field;
        logic [1:0] node;
        logic [1:0] color;
    } req_t;

    function automatic logic [7:0] field_char(input logic [1:0] field);
        logic [7:0] c;
        unique case (field)
            2'd0:    c = CH_M;
            2'd1:    c = CH_P;
            2'd2:    c = CH_N;
            default: c = CH_V;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] color_char(input logic [1:0] color);
        logic [7:0] c;
        unique case (color)
            2'd1:    c = CH_P;
            2'd2:    c = CH_W;
            2'd3:    c = CH_N;
            default: c = CH_BAD;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] node_char(input logic [1:0] node);
        logic [7:0] c;
        unique case (node)
            2'd1:    c = CH_1;
            2'd2:    c = CH_2;
            2'd3:    c = CH_3;
            default: c = CH_BAD;
        endcase
        return c;
    endfunction

    // Total bytes of a message, including the optional trailing newline.
    function automatic logic [3:0] msg_len(input msg_type_e mtype, input logic nl);
        logic [3:0] n;
        unique case (mtype)
            MsgEnd:  n = 4'd5;
            MsgSi:   n = 4'd11;
            default: n = 4'd12;
        endcase
        return n + {3'b000, nl};
    endfunction

    // Byte at position idx; any index past the body is the newline.
    function automatic logic [7:0] msg_byte(input req_t r, input logic [3:0] idx);
        logic [7:0] b;
        logic [7:0] fc;
        logic [7:0] nc;
        logic [7:0] cc;
        fc = field_char(r.field);
        nc = node_char(r.node);
        cc = color_char(r.color);
        b  = CH_NL;
        unique case (r.mtype)
            MsgEnd: begin
                case (idx)
                    4'd0:    b = CH_E;
                    4'd1:    b = CH_N;
                    4'd2:    b = CH_D;
                    4'd3:    b = CH_DASH;
                    4'd4:    b = CH_HASH;
                    default: b = CH_NL;
                endcase
            end
            MsgSi: begin
                case (idx)
                    4'd0:    b = CH_S;
                    4'd1:    b = CH_I;
                    4'd2:    b = CH_DASH;
                    4'd3:    b = CH_S;
                    4'd4:    b = CH_I;
                    4'd5:    b = fc;
                    4'd6:    b = nc;
                    4'd7:    b = CH_DASH;
                    4'd8:    b = cc;
                    4'd9:    b = CH_DASH;
                    4'd10:   b = CH_HASH;
                    default: b = CH_NL;
                endcase
            end
            default: begin
                case (idx)
                    4'd0:    b = CH_S;
                    4'd1:    b = CH_DASH;
                    4'd2:    b = (r.mtype == MsgSpim) ? CH_P : CH_D;
                    4'd3:    b = CH_DASH;
                    4'd4:    b = CH_D;
                    4'd5:    b = CH_Z;
                    4'd6:    b = fc;
                    4'd7:    b = nc;
                    4'd8:    b = CH_DASH;
                    4'd9:    b = cc;
                    4'd10:   b = CH_DASH;
                    4'd11:   b = CH_HASH;
                    default: b = CH_NL;
                endcase
            end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sm_uart_byte_tx.sv
// Byte-level 8N1 UART serialiser. ready rises in the last stop-bit cycle so a new
// start can follow with no idle gap. CLKS_PER_BIT must be at least 2.
module sm_uart_byte_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

    logic          active;
    logic [CW-1:0] clk_cnt;
    // 0 = start bit, 1..8 = data bits, 9 = stop bit
    logic [3:0]    bit_idx;
    logic [7:0]    shift;

    // Bit timing, shifting and line drive.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= 4'd0;
            shift   <= 8'd0;
            tx      <= 1'b1;
            ready   <= 1'b1;
        end else if (start && ready) begin
            active  <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= 4'd0;
            shift   <= data;
            tx      <= 1'b0;
            ready   <= 1'b0;
        end else if (active) begin
            if (clk_cnt == CNT_LAST) begin
                clk_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx < 4'd8) begin
                        tx    <= shift[0];
                        shift <= {1'b0, shift[7:1]};
                    end else begin
                        tx <= 1'b1;
                    end
                end
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
                if (bit_idx == 4'd9 && clk_cnt == CNT_PRE) begin
                    ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sm_xbee_msg_tx.sv
// Xbee message transmitter: request FIFO, message expansion controller and UART serialiser.
module sm_xbee_msg_tx
    import sm_xbee_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 50000000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned APPEND_NEWLINE = 1
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_type,
    input  logic [1:0] req_field,
    input  logic [1:0] req_node,
    input  logic [1:0] req_color,
    output logic       busy,
    output logic       msg_done,
    output logic       req_err,
    output logic       tx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic NL = (APPEND_NEWLINE != 0);

    // ---------------- request FIFO ----------------
    req_t        mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        req_bad;
    logic        push;
    logic        pop;

    ctrl_state_e state;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready = !full;
    // END carries no node/color, so only the other types are validated.
    assign req_bad   = (req_type != 2'd0) && ((req_node == 2'd0) || (req_color == 2'd0));
    assign push      = req_valid && !full && !req_bad;
    assign pop       = (state == StIdle) && !empty;

    // FIFO storage write.
    always_ff @(posedge clk_50M) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{mtype: msg_type_e'(req_type), field: req_field,
                                     node: req_node, color: req_color};
        end
    end

    // FIFO pointers and the rejected-request pulse.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            req_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            req_err <= req_valid && !full && req_bad;
        end
    end

    // ---------------- controller ----------------
    req_t       cur;
    logic [3:0] len;
    logic [3:0] idx;
    logic [7:0] data;
    logic       pend;
    logic       ser_ready;
    logic       ser_start;

    // A byte is handed over in the cycle the serialiser reports ready.
    assign ser_start = (state == StSend) && pend && ser_ready;
    assign busy      = (state != StIdle) || !empty;

    // Message sequencing: pop, load first byte, feed bytes, signal completion.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            cur      <= '0;
            len      <= 4'd0;
            idx      <= 4'd0;
            data     <= 8'd0;
            pend     <= 1'b0;
            msg_done <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!empty) begin
                        cur   <= mem[rd_ptr[AW-1:0]];
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    len   <= msg_len(cur.mtype, NL);
                    idx   <= 4'd0;
                    data  <= msg_byte(cur, 4'd0);
                    pend  <= 1'b1;
                    state <= StSend;
                end
                StSend: begin
                    if (pend) begin
                        if (ser_ready) begin
                            if (idx == len - 4'd1) begin
                                pend <= 1'b0;
                            end else begin
                                idx  <= idx + 4'd1;
                                data <= msg_byte(cur, idx + 4'd1);
                            end
                        end
                    end else if (ser_ready) begin
                        // ready returns in the final stop-bit cycle of the last byte
                        msg_done <= 1'b1;
                        state    <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    sm_uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk_50M(clk_50M),
        .rst    (rst),
        .data   (data),
        .start  (ser_start),
        .ready  (ser_ready),
        .tx     (tx)
    );

endmodule

// File: tb/tb_sm_xbee_msg_tx.sv
// Self-checking bench for sm_xbee_msg_tx with a UART receiver and a string-level message model.
module tb_sm_xbee_msg_tx;

    localparam int unsigned CLK_FREQ = 460800;
    localparam int unsigned BAUD     = 115200;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v0, v1, rdy0, rdy1, busy0, busy1, done0, done1, err0, err1, tx0, tx1;
    logic [1:0] t0, f0, n0, c0, t1, f1, n1, c1;
    logic [1:0] txv, busyv, readyv, donev;

    assign txv    = {tx1, tx0};
    assign busyv  = {busy1, busy0};
    assign readyv = {rdy1, rdy0};
    assign donev  = {done1, done0};

    sm_xbee_msg_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(4), .APPEND_NEWLINE(1)) dut0 (
        .clk_50M(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_type(t0),
        .req_field(f0), .req_node(n0), .req_color(c0), .busy(busy0), .msg_done(done0),
        .req_err(err0), .tx(tx0)
    );

    sm_xbee_msg_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(4), .APPEND_NEWLINE(0)) dut1 (
        .clk_50M(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_type(t1),
        .req_field(f1), .req_node(n1), .req_color(c1), .busy(busy1), .msg_done(done1),
        .req_err(err1), .tx(tx1)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q0[$], exp_q1[$], rx_q0[$], rx_q1[$];
    int frame_err0 = 0, frame_err1 = 0;
    int done_cnt0 = 0, done_cnt1 = 0, err_cnt0 = 0, err_cnt1 = 0;
    bit stall_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Message text built straight from the documented formats.
    function automatic string model_msg(input int t, input int f, input int n, input int c,
                                        input bit nl);
        string fch;
        string cch;
        string s;
        fch = "MPNV";
        cch = "?PWN";
        case (t)
            0:       s = "END-#";
            1:       s = $sformatf("SI-SI%c%0d-%c-#", fch[f], n, cch[c]);
            2:       s = $sformatf("S-P-DZ%c%0d-%c-#", fch[f], n, cch[c]);
            default: s = $sformatf("S-D-DZ%c%0d-%c-#", fch[f], n, cch[c]);
        endcase
        if (nl) s = {s, "\n"};
        return s;
    endfunction

    task automatic drive(input int ch, input logic v, input int t, input int f, input int n,
                         input int c);
        if (ch == 0) begin
            v0 = v; t0 = 2'(t); f0 = 2'(f); n0 = 2'(n); c0 = 2'(c);
        end else begin
            v1 = v; t1 = 2'(t); f1 = 2'(f); n1 = 2'(n); c1 = 2'(c);
        end
    endtask

    // Returns #1 after the accepting edge; inputs are scrambled afterwards.
    task automatic push(input int ch, input int t, input int f, input int n, input int c);
        int guard;
        string s;
        guard = 0;
        @(negedge clk);
        drive(ch, 1'b1, t, f, n, c);
        if (readyv[ch] !== 1'b1) stall_seen = 1;
        while (readyv[ch] !== 1'b1 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", 32'(guard < 4000), 32'd1);
        @(posedge clk);
        #1;
        drive(ch, 1'b0, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        if (!(t != 0 && (n == 0 || c == 0))) begin
            s = model_msg(t, f, n, c, ch == 0);
            for (int i = 0; i < s.len(); i++) begin
                if (ch == 0) exp_q0.push_back(8'(s[i]));
                else exp_q1.push_back(8'(s[i]));
            end
        end
    endtask

    task automatic wait_idle(input int ch);
        int g;
        g = 0;
        while (busyv[ch] !== 1'b0 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        check("idle_wait", 32'(g < 20000), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // lat: edges from acceptance to start bit; dur: edges from start bit to msg_done.
    task automatic time_msg(input int ch, output int lat, output int dur);
        lat = 0;
        dur = 0;
        do begin @(posedge clk); #1; lat++; end while (txv[ch] !== 1'b0 && lat < 100);
        do begin @(posedge clk); #1; dur++; end while (donev[ch] !== 1'b1 && dur < 2000);
    endtask

    task automatic check_stream(input int ch, input string tag);
        logic [7:0] got[$];
        logic [7:0] want[$];
        if (ch == 0) begin
            got = rx_q0; want = exp_q0; rx_q0.delete(); exp_q0.delete();
        end else begin
            got = rx_q1; want = exp_q1; rx_q1.delete(); exp_q1.delete();
        end
        check({tag, "_len"}, 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            check(tag, {24'd0, got[i]}, {24'd0, want[i]});
        end
    endtask

    // UART receiver sampling mid-bit on the falling clock edge.
    task automatic rx_loop(input int ch);
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txv[ch] === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (txv[ch] !== 1'b0) begin
                    if (ch == 0) frame_err0++; else frame_err1++;
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txv[ch];
                end
                repeat (CPB) @(negedge clk);
                if (txv[ch] !== 1'b1) begin
                    if (ch == 0) frame_err0++; else frame_err1++;
                end
                if (ch == 0) rx_q0.push_back(b); else rx_q1.push_back(b);
            end
        end
    endtask

    initial rx_loop(0);
    initial rx_loop(1);

    initial begin : pulse_mon
        forever begin
            @(negedge clk);
            if (done0 === 1'b1) done_cnt0++;
            if (done1 === 1'b1) done_cnt1++;
            if (err0 === 1'b1) err_cnt0++;
            if (err1 === 1'b1) err_cnt1++;
        end
    end

    initial begin : main
        int lat, dur, d, e, nvalid, low_seen;
        int rt, rf, rn, rc;
        rst = 1'b1;
        drive(0, 1'b0, 0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_ready", 32'(rdy0), 32'd1);
        check("rst_tx1", 32'(tx1), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single SI message: latency, duration, busy release
        push(0, 1, 0, 3, 3);
        time_msg(0, lat, dur);
        check("si_latency", 32'(lat), 32'd3);
        check("si_duration", 32'(dur), 32'd480);
        @(posedge clk);
        #1;
        check("si_busy_fall", 32'(busy0), 32'd0);
        check("si_done_pulse", 32'(done0), 32'd0);
        wait_idle(0);
        check_stream(0, "si_stream");
        check("si_frame_err", 32'(frame_err0), 32'd0);

        // Three back-to-back requests
        d = done_cnt0;
        push(0, 2, 3, 1, 2);
        push(0, 3, 1, 2, 1);
        push(0, 0, 0, 0, 0);
        wait_idle(0);
        check_stream(0, "b2b_stream");
        check("b2b_done_cnt", 32'(done_cnt0 - d), 32'd3);
        check("b2b_frame_err", 32'(frame_err0), 32'd0);

        // Overfill: six requests into a depth-4 FIFO
        stall_seen = 0;
        d = done_cnt0;
        push(0, 1, 2, 1, 1);
        push(0, 0, 0, 0, 0);
        push(0, 2, 0, 3, 3);
        push(0, 3, 3, 2, 2);
        push(0, 1, 1, 1, 3);
        push(0, 0, 2, 2, 2);
        check("fill_stall_seen", 32'(stall_seen), 32'd1);
        wait_idle(0);
        check_stream(0, "fill_stream");
        check("fill_done_cnt", 32'(done_cnt0 - d), 32'd6);

        // Invalid request: SPiM with node 0
        e = err_cnt0;
        push(0, 2, 1, 0, 1);
        check("bad_err_pulse", 32'(err0), 32'd1);
        @(posedge clk);
        #1;
        check("bad_err_one_cycle", 32'(err0), 32'd0);
        check("bad_busy", 32'(busy0), 32'd0);
        low_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx0 !== 1'b1) low_seen = 1;
        end
        check("bad_no_start", 32'(low_seen), 32'd0);
        check("bad_err_cnt", 32'(err_cnt0 - e), 32'd1);

        // Reset in the middle of the 5th byte of an SI message
        push(0, 1, 1, 2, 2);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (tx0 !== 1'b0 && lat < 100);
        repeat (160) @(posedge clk);
        #1;
        check("rst_byte5_start", 32'(tx0), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx0), 32'd1);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_ready", 32'(rdy0), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        rx_q0.delete();
        exp_q0.delete();
        frame_err0 = 0;
        push(0, 0, 1, 2, 3);
        wait_idle(0);
        check_stream(0, "post_rst_stream");
        check("post_rst_frame_err", 32'(frame_err0), 32'd0);

        // No trailing newline variant
        d = done_cnt1;
        push(1, 3, 0, 2, 1);
        time_msg(1, lat, dur);
        check("nonl_latency", 32'(lat), 32'd3);
        check("nonl_duration", 32'(dur), 32'd480);
        wait_idle(1);
        check_stream(1, "nonl_stream");
        check("nonl_done_cnt", 32'(done_cnt1 - d), 32'd1);
        check("nonl_frame_err", 32'(frame_err1), 32'd0);

        // Random request mix, including invalid ones, with random gaps
        d = done_cnt0;
        e = err_cnt0;
        nvalid = 0;
        for (int k = 0; k < 12; k++) begin
            rt = int'($urandom_range(0, 3));
            rf = int'($urandom_range(0, 3));
            rn = int'($urandom_range(0, 3));
            rc = int'($urandom_range(0, 3));
            if (rt == 0 || (rn != 0 && rc != 0)) nvalid++;
            push(0, rt, rf, rn, rc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(0);
        check_stream(0, "rand_stream");
        check("rand_done_cnt", 32'(done_cnt0 - d), 32'(nvalid));
        check("rand_err_cnt", 32'(err_cnt0 - e), 32'(12 - nvalid));
        check("rand_frame_err", 32'(frame_err0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
